// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller signal bundle: the pipeline (master) drives stage addresses and control bits,
// the controller (slave) returns forwarding selects, stalls, flushes and status.
interface pipeline_hazard_controller_if;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic        MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemErr;
  logic [15:0] StallCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Forwarding, stall/flush generation and data-memory wait FSM with timeout watchdog.
// Define HAZARD_PERF_CNT_EN to build the saturating stalled-cycle counter.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {StRun, StWait, StRelease} state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [8:0] w_seen;
  logic       r_mem_err, w_mem_err_next;
  logic       w_ldrstall, w_pcpend, w_hold_raw, w_memhold;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic rwm,
                                         input logic [3:0] wam, input logic rww,
                                         input logic [3:0] waw);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'd15) begin
      if (rwm && (ra == wam))      sel = 2'b10;
      else if (rww && (ra == waw)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_ldrstall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
  assign w_pcpend   = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign w_hold_raw = hz.MemReqM && !hz.MemReadyM;
  // The release cycle abandons the access so the pipeline can drain.
  assign w_memhold  = w_hold_raw && (r_state != StRelease);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StRun;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_mem_err <= w_mem_err_next;
    end
  end

  // w_seen counts the current not-ready cycle, so RELEASE follows the MEM_TIMEOUT-th one.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_mem_err_next = r_mem_err;
    w_seen         = {1'b0, r_cnt} + 9'd1;
    unique case (r_state)
      StRun, StWait: begin
        if (w_hold_raw) begin
          if (w_seen >= 9'(MEM_TIMEOUT)) begin
            w_state_next   = StRelease;
            w_cnt_next     = '0;
            w_mem_err_next = 1'b1;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = w_seen[7:0];
          end
        end else begin
          w_state_next = StRun;
          w_cnt_next   = '0;
        end
      end
      StRelease: begin
        w_state_next = StRun;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = StRun;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    if (reset) begin
      hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      if (w_memhold) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else begin
        hz.StallF = w_ldrstall || w_pcpend;
        hz.StallD = w_ldrstall;
        hz.FlushD = w_pcpend || hz.PCSrcW || hz.BranchTakenE;
        hz.FlushE = w_ldrstall || hz.BranchTakenE;
      end
    end
  end

  assign hz.MemErr = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (hz.StallF && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign hz.StallCount = r_stall_cnt;
`else
  assign hz.StallCount = 16'd0;
`endif

endmodule
